sram_stream_reader: RTL and testbench
=====================================

# sram_stream_reader

Read-side controller for the 2048×32 single-port SRAM macro used for activation and weight storage in the systolic-array datapath. On a `start` command it drives CEN/WEN/A to burst-read `len` consecutive words from `base_addr`, with modulo-2048 wrap. It captures the macro's Q output into a 4-entry output FIFO and presents the words on a valid/ready stream toward the array feeder. The stream sustains one word per cycle and absorbs downstream backpressure without losing or duplicating data.

## Interface
Parameters:
- `ADDR_W`, 11, SRAM address width.
- `DATA_W`, 32, SRAM word width.
- `FIFO_D`, 4, output FIFO depth; the credit rule below requires exactly 4.

Ports:
- `CLK`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; sampled with `start`.
- `len`  in  ADDR_W+1  word count, 1..4095. Counts above 2048 re-read via wrap.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle after the last word is popped.
- `done`  out  1  one-cycle pulse in the cycle after the last word's pop.
- `CEN`  out  1  SRAM chip enable, active-low; registered.
- `WEN`  out  1  SRAM write enable; held 1 (read) always.
- `A`  out  ADDR_W  SRAM address; registered.
- `Q`  in  DATA_W  SRAM read data. Valid the cycle after the edge that sampled CEN=0.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  DATA_W  FIFO head word.
- `out_ready`  in  1  consumer accept. Pop occurs at an edge where `out_valid && out_ready`.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE:
  - `start=1 && len!=0` → RUN. Latch `base_addr` into the address counter and `len` into `remaining`.
  - `len==0` → command ignored; stay IDLE, no `busy`, no `done`.
- RUN:
  - Issue a read at an edge iff `occupancy + inflight < 4`, where `inflight` is the number of reads issued but not yet captured (0..2).
  - Issue: CEN←0, A←addr, addr←addr+1 mod 2048, remaining←remaining−1.
  - No issue: CEN←1; A holds.
  - Go to FLUSH at the edge that issues the last word (remaining 1→0).
- FLUSH: CEN=1. Wait until `inflight==0` and FIFO is empty, then → IDLE and pulse `done`.
- Capture: a read issued at edge k is written into the FIFO at edge k+2 from Q. Push and pop in the same edge are both legal; occupancy is unchanged.
- FIFO: circular 4-entry, 2-bit pointers plus 3-bit occupancy. Ordering is strictly issue order. Overflow is impossible by the credit rule.
- `start` while `busy` is ignored, with no effect on the current burst.
- Reset mid-burst:
  - Next cycle: CEN=1, state IDLE, FIFO emptied, inflight cleared, `done` not pulsed.
  - Q data arriving after reset is discarded.
- Reset values: CEN=1, WEN=1, A=0, out_valid=0, out_data=0, busy=0, done=0.

## Timing
- `start` sampled at edge e0. CEN=0, A=base after e0. Q valid after e1. Captured at e2. `out_valid=1` after e2.
- First-word latency is 3 cycles from start sample to `out_valid`.
- With `out_ready` held 1: one word per cycle, no bubbles. A len-N burst shows `out_valid` for N consecutive cycles.
- With `out_ready=0`: issue stops after at most 4 words are buffered or in flight. Throughput resumes the cycle after `out_ready` rises.
- `busy` deasserts and `done` pulses in the same cycle, one cycle after the final pop.
- A new `start` is accepted in that cycle, since the FSM is in IDLE.

## Structure
- Shared package `sram_pkg`:
  - ADDR_W=11, DATA_W=32, DEPTH=2048.
  - FSM state enum {IDLE, RUN, FLUSH}.
  - Shared with the write-side controller.
- One sub-module: `sram_rd_fifo`, the 4-entry FIFO with push/pop/occupancy. The top holds the FSM, address/remaining counters, and the 2-bit inflight shift register.
- Bench instantiates the SRAM macro behavioural model directly on CEN/WEN/A/Q.

## Test plan
- Preload mem[k]=k+0x100. start, base=5, len=8, out_ready=1 → words 0x105..0x10C on 8 consecutive valid cycles; first valid 3 cycles after start; `done` one cycle after the last pop.
- base=2045, len=6 → addresses 2045, 2046, 2047, 0, 1, 2 in order (wrap).
- len=10 with out_ready low for cycles 4–12 → at most 4 reads outstanding (CEN=0 for exactly 4 edges, then held 1); all 10 words delivered in order with no duplicates.
- len=0 start → busy and done stay 0, CEN stays 1. Then `start` asserted during an active len=20 burst → ignored; exactly 20 words delivered.
- reset asserted 5 cycles into a len=20 burst → next cycle CEN=1, out_valid=0, busy=0, no done. A following len=3 burst returns only its own 3 words.
- Random out_ready (50%) over len=2048, base=0 → scoreboard matches all 2048 words; `WEN` never 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the 2048x32 SRAM read/write controllers.
package sram_pkg;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2048;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
endpackage

// File: rtl/sram_rd_fifo.sv
// Small circular FIFO that buffers SRAM read data ahead of the stream output.
module sram_rd_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [PTR_W:0]    count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    assign head = mem[rd_ptr];

    // Entries are cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sram_stream_reader.sv
// Burst-reads consecutive SRAM words (address wraps) and streams them out
// over valid/ready, throttled by FIFO credit so backpressure never drops data.
module sram_stream_reader #(
    parameter int ADDR_W = sram_pkg::ADDR_W,
    parameter int DATA_W = sram_pkg::DATA_W,
    parameter int FIFO_D = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              CEN,
    output logic              WEN,
    output logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Q,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);
    import sram_pkg::*;

    localparam int CNT_W = $clog2(FIFO_D) + 1;
    localparam logic [ADDR_W:0] ONE_WORD = 1;
    localparam logic [CNT_W:0]  CREDITS  = (CNT_W+1)'(FIFO_D);
    localparam logic [CNT_W-1:0] ONE_ENTRY = 1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [1:0]        inflight_sr;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W:0]    credit_used;
    logic              accept;
    logic              issue;
    logic              pop;
    logic              drained;

    assign WEN       = 1'b1;
    assign out_valid = (occupancy != '0);
    assign pop       = out_valid && out_ready;
    assign accept    = (state == IDLE) && start && (len != '0);

    // Reads in flight count against FIFO space so a stalled consumer can never overflow it.
    assign credit_used = (CNT_W+1)'(occupancy) + (CNT_W+1)'(inflight_sr[0])
                       + (CNT_W+1)'(inflight_sr[1]);
    assign issue   = accept || ((state == RUN) && (credit_used < CREDITS));
    assign drained = (inflight_sr == 2'b00)
                   && ((occupancy == '0) || (pop && occupancy == ONE_ENTRY));

    // The accepting edge already issues the first read to hit the 3-cycle latency.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            inflight_sr <= '0;
            CEN         <= 1'b1;
            A           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            inflight_sr <= {inflight_sr[0], issue};
            CEN         <= ~issue;
            done        <= 1'b0;
            if (issue) begin
                A <= accept ? base_addr : addr;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr      <= base_addr + 1'b1;
                        remaining <= len - 1'b1;
                        busy      <= 1'b1;
                        state     <= (len == ONE_WORD) ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == ONE_WORD) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (drained) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sram_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_D)
    ) u_fifo (
        .clk       (CLK),
        .reset     (reset),
        .push      (inflight_sr[1]),
        .push_data (Q),
        .pop       (pop),
        .head      (out_data),
        .count     (occupancy)
    );
endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader driving a behavioural SRAM macro.
module tb_sram_stream_reader;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              CEN;
    logic              WEN;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] Q;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    logic [DATA_W-1:0] mem [2048];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_word;
    int compared   = 0;
    int mismatched = 0;
    int pops       = 0;
    bit rand_ready = 1'b0;
    bit wen_bad    = 1'b0;

    always #5 CLK = ~CLK;

    sram_stream_reader dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .CEN       (CEN),
        .WEN       (WEN),
        .A         (A),
        .Q         (Q),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    // Behavioural SRAM macro: read data appears after the edge that samples CEN low.
    always @(posedge CLK) begin
        if (!CEN && WEN) Q <= mem[A];
    end

    // Monitor: every accepted word is checked against the head of the expected queue.
    always @(negedge CLK) begin
        if (WEN !== 1'b1) wen_bad = 1'b1;
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            pops++;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_word: got %h, expected no word", out_data);
            end else begin
                exp_word = exp_q.pop_front();
                if (out_data !== exp_word) begin
                    mismatched++;
                    $display("[TB] FAIL stream_word: got %h, expected %h", out_data, exp_word);
                end
            end
        end
    end

    always @(posedge CLK) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives a one-cycle start and queues the words the burst should deliver.
    task automatic apply_stimulus(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                                  input int n_expect);
        start     = 1'b1;
        base_addr = b;
        len       = n;
        for (int i = 0; i < n_expect; i++) begin
            exp_q.push_back(32'h100 + 32'((int'(b) + i) % 2048));
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check_output(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int n_valid;
        int cen_low;
        int pops_before;
        bit seen;
        bit bad;

        reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1; Q = '0;
        for (int k = 0; k < 2048; k++) mem[k] = 32'h100 + 32'(k);
        repeat (2) tick();
        check_output("rst_cen", 32'(CEN), 32'd1);
        check_output("rst_wen", 32'(WEN), 32'd1);
        check_output("rst_a", 32'(A), 32'd0);
        check_output("rst_valid", 32'(out_valid), 32'd0);
        check_output("rst_data", out_data, 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        // Basic burst: latency, back-to-back words, done timing.
        apply_stimulus(11'd5, 12'd8, 8);
        check_output("t1_busy", 32'(busy), 32'd1);
        check_output("t1_cen_first", 32'(CEN), 32'd0);
        check_output("t1_a_first", 32'(A), 32'd5);
        check_output("t1_valid_e0", 32'(out_valid), 32'd0);
        tick();
        check_output("t1_valid_e1", 32'(out_valid), 32'd0);
        tick();
        check_output("t1_valid_e2", 32'(out_valid), 32'd1);
        check_output("t1_first_word", out_data, 32'h105);
        n_valid = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
            else if (out_valid) n_valid++;
        end
        check_output("t1_done_seen", 32'(seen), 32'd1);
        check_output("t1_valid_cycles", 32'(n_valid), 32'd8);
        check_output("t1_busy_at_done", 32'(busy), 32'd0);
        check_output("t1_valid_at_done", 32'(out_valid), 32'd0);
        tick();
        check_output("t1_done_pulse", 32'(done), 32'd0);

        // Address wrap at the top of the array.
        apply_stimulus(11'd2045, 12'd6, 6);
        wait_done("t2_done", 40);
        check_output("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: only four reads may be outstanding.
        out_ready = 1'b0;
        apply_stimulus(11'd40, 12'd10, 10);
        cen_low = (CEN == 1'b0) ? 1 : 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (CEN == 1'b0) cen_low++;
        end
        check_output("t3_reads_outstanding", 32'(cen_low), 32'd4);
        check_output("t3_valid_stalled", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_done("t3_done", 60);
        check_output("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Zero-length command, then a start during an active burst.
        start = 1'b1; base_addr = 11'd9; len = '0;
        tick();
        start = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy || done || !CEN) bad = 1'b1;
            tick();
        end
        check_output("t4_len0_ignored", 32'(bad), 32'd0);
        pops_before = pops;
        apply_stimulus(11'd100, 12'd20, 20);
        repeat (3) tick();
        start = 1'b1; base_addr = 11'd500; len = 12'd5;
        tick();
        start = 1'b0;
        check_output("t4_busy_kept", 32'(busy), 32'd1);
        wait_done("t4_done", 80);
        check_output("t4_word_count", 32'(pops - pops_before), 32'd20);
        check_output("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a burst.
        apply_stimulus(11'd300, 12'd20, 20);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check_output("t5_cen", 32'(CEN), 32'd1);
        check_output("t5_valid", 32'(out_valid), 32'd0);
        check_output("t5_busy", 32'(busy), 32'd0);
        check_output("t5_done", 32'(done), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done || out_valid) bad = 1'b1;
        end
        check_output("t5_quiet_after_reset", 32'(bad), 32'd0);
        pops_before = pops;
        apply_stimulus(11'd7, 12'd3, 3);
        wait_done("t5_done_next", 30);
        check_output("t5_word_count", 32'(pops - pops_before), 32'd3);
        check_output("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Full-array burst with random consumer backpressure.
        rand_ready = 1'b1;
        pops_before = pops;
        apply_stimulus(11'd0, 12'd2048, 2048);
        wait_done("t6_done", 12000);
        rand_ready = 1'b0;
        repeat (2) tick();
        out_ready = 1'b1;
        check_output("t6_word_count", 32'(pops - pops_before), 32'd2048);
        check_output("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        check_output("t6_wen_never_low", 32'(wen_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
